mod_exp_controller: RTL

- Sequencer that computes result = base^exponent mod modulus for RSA encrypt/decrypt using right-to-left-free, MSB-first square-and-multiply in the Montgomery domain.
- Sits directly upstream of the 64-bit Montgomery multiplier and drives its A/B/M/go inputs. It consumes that multiplier's S/done outputs and issues one multiply at a time.
- Conversion into the Montgomery domain uses the precomputed r2_mod = (2^BITS)^2 mod modulus. Conversion out uses a multiply by 1.

---
 rtl/mod_exp_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mod_exp_controller.sv
// mod_exp_controller: MSB-first Montgomery square-and-multiply sequencer driving
// a single external Montgomery multiplier, one multiply at a time.
module mod_exp_controller #(
    parameter int BITS     = 64,
    parameter int EXP_BITS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BITS-1:0]     base,
    input  logic [EXP_BITS-1:0] exponent,
    input  logic [BITS-1:0]     modulus,
    input  logic [BITS-1:0]     r2_mod,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [BITS-1:0]     result,
    output logic [BITS-1:0]     mm_a,
    output logic [BITS-1:0]     mm_b,
    output logic [BITS-1:0]     mm_m,
    output logic                mm_go,
    input  logic                mm_done,
    input  logic [BITS-1:0]     mm_s
);
    localparam int KW = $clog2(EXP_BITS) + 1;
    localparam logic [BITS-1:0] ONE = BITS'(1);
    typedef enum logic [2:0] {IDLE, CHECK, PRE_X, PRE_A, SQ, MUL, POST, FINISH} state_t;
    state_t state, state_n;
    logic [1:0] gap, gap_n;
    logic [KW-1:0] k, k_n;
    logic [BITS-1:0] base_r, mod_r, r2_r, xbar, abar, xbar_n, abar_n, result_n;
    logic [EXP_BITS-1:0] exp_r;
    logic busy_n, done_n, error_n, latch, op, fire, bad, bit_k, last;
    assign op    = state inside {PRE_X, PRE_A, SQ, MUL, POST};
    assign mm_go = op && gap == 2'd0;
    assign fire  = mm_go && mm_done;
    assign mm_m  = mod_r;
    assign bad   = !mod_r[0] || mod_r < BITS'(3) || base_r >= mod_r;
    assign bit_k = exp_r[k[KW-2:0]];
    assign last  = k == '0;
    always_comb begin
        state_n  = state;
        gap_n    = gap - {1'b0, |gap};
        k_n      = k;
        xbar_n   = xbar;
        abar_n   = abar;
        result_n = result;
        busy_n   = busy;
        done_n   = 1'b0;
        error_n  = error;
        latch    = 1'b0;
        mm_a     = '0;
        mm_b     = '0;
        case (state)
            IDLE: if (start && !done) begin
                latch   = 1'b1;
                busy_n  = 1'b1;
                error_n = 1'b0;
                state_n = CHECK;
            end
            CHECK: begin
                error_n = bad;
                state_n = bad ? FINISH : PRE_X;
            end
            PRE_X: begin
                mm_a = base_r;
                mm_b = r2_r;
                if (fire) begin
                    xbar_n  = mm_s;
                    gap_n   = 2'd2;
                    state_n = PRE_A;
                end
            end
            PRE_A: begin
                mm_a = ONE;
                mm_b = r2_r;
                if (fire) begin
                    abar_n  = mm_s;
                    gap_n   = 2'd2;
                    k_n     = KW'(EXP_BITS - 1);
                    state_n = SQ;
                end
            end
            SQ: begin
                mm_a = abar;
                mm_b = abar;
                if (fire) begin
                    abar_n  = mm_s;
                    gap_n   = 2'd2;
                    state_n = bit_k ? MUL : last ? POST : SQ;
                    k_n     = (bit_k || last) ? k : k - 1'b1;
                end
            end
            MUL: begin
                mm_a = abar;
                mm_b = xbar;
                if (fire) begin
                    abar_n  = mm_s;
                    gap_n   = 2'd2;
                    state_n = last ? POST : SQ;
                    k_n     = last ? k : k - 1'b1;
                end
            end
            POST: begin
                mm_a = abar;
                mm_b = ONE;
                if (fire) begin
                    abar_n  = mm_s;
                    state_n = FINISH;
                end
            end
            default: begin
                result_n = error ? '0 : abar;
                done_n   = 1'b1;
                busy_n   = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gap    <= '0;
            k      <= '0;
            base_r <= '0;
            mod_r  <= '0;
            r2_r   <= '0;
            exp_r  <= '0;
            xbar   <= '0;
            abar   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            state  <= state_n;
            gap    <= gap_n;
            k      <= k_n;
            xbar   <= xbar_n;
            abar   <= abar_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            error  <= error_n;
            if (latch) begin
                base_r <= base;
                mod_r  <= modulus;
                r2_r   <= r2_mod;
                exp_r  <= exponent;
            end
        end
    end
endmodule
